pipe_wb_stage: RTL and testbench

Write-back stage that consumes the MEM/WB pipeline register outputs and commits results to architectural state. It selects the register-file write data and drives the RF write port. It owns the HI/LO special registers and updates them from MTHI/MTLO, MULT(U) and DIV(U) results. It provides write-through HI/LO read ports to the ID/EX stages and an RF bypass tap for the forwarding unit.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_hilo_reg.sv | 70 +++++++
 rtl/pipe_wb_stage.sv | 95 +++++++++
 tb/tb_pipe_wb_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the write-back stage: RF and HI/LO source selects
// and control levels.
package pipe_pkg;

  localparam logic [2:0] RF_SEL_ALU  = 3'd0;
  localparam logic [2:0] RF_SEL_DMEM = 3'd1;
  localparam logic [2:0] RF_SEL_PC4  = 3'd2;
  localparam logic [2:0] RF_SEL_CLZ  = 3'd3;
  localparam logic [2:0] RF_SEL_CP0  = 3'd4;
  localparam logic [2:0] RF_SEL_HI   = 3'd5;
  localparam logic [2:0] RF_SEL_LO   = 3'd6;
  localparam logic [2:0] RF_SEL_MUL  = 3'd7;

  localparam logic [1:0] HL_SEL_RS   = 2'd0;
  localparam logic [1:0] HL_SEL_MUL  = 2'd1;
  localparam logic [1:0] HL_SEL_DIV  = 2'd2;
  localparam logic [1:0] HL_SEL_HOLD = 2'd3;

  localparam logic RST_ENABLED   = 1'b1;
  localparam logic WRITE_ENABLED = 1'b1;

endpackage

// File: rtl/pipe_hilo_reg.sv
// HI/LO special registers with next-value muxes and write-through reads.
module pipe_hilo_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [1:0]        hi_sel,
  input  logic [1:0]        lo_sel,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic [DATA_W-1:0] mul_lo,
  input  logic [DATA_W-1:0] div_r,
  input  logic [DATA_W-1:0] div_q,
  input  logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  logic [DATA_W-1:0] hi_next;
  logic [DATA_W-1:0] lo_next;
  logic              hi_wr;
  logic              lo_wr;

  assign hi_wr = (hi_we == WRITE_ENABLED) && (hi_sel != HL_SEL_HOLD);
  assign lo_wr = (lo_we == WRITE_ENABLED) && (lo_sel != HL_SEL_HOLD);

  always_comb begin
    hi_next = hi_q;
    unique case (hi_sel)
      HL_SEL_RS:   hi_next = rs_data;
      HL_SEL_MUL:  hi_next = mul_hi;
      HL_SEL_DIV:  hi_next = div_r;
      HL_SEL_HOLD: hi_next = hi_q;
      default:     hi_next = hi_q;
    endcase
  end

  always_comb begin
    lo_next = lo_q;
    unique case (lo_sel)
      HL_SEL_RS:   lo_next = rs_data;
      HL_SEL_MUL:  lo_next = mul_lo;
      HL_SEL_DIV:  lo_next = div_q;
      HL_SEL_HOLD: lo_next = lo_q;
      default:     lo_next = lo_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLED) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_wr) hi_q <= hi_next;
      if (lo_wr) lo_q <= lo_next;
    end
  end

  // Readers in ID see a pending write this cycle, never the stale value.
  assign hi_rdata = (rst == RST_ENABLED) ? '0 :
                    hi_wr ? hi_next : hi_q;
  assign lo_rdata = (rst == RST_ENABLED) ? '0 :
                    lo_wr ? lo_next : lo_q;

endmodule

// File: rtl/pipe_wb_stage.sv
// Write-back stage: RF write mux/gating, HI/LO ownership, forwarding tap.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module pipe_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_mul_hi,
  input  logic [DATA_W-1:0] wb_mul_lo,
  input  logic [DATA_W-1:0] wb_div_r,
  input  logic [DATA_W-1:0] wb_div_q,
  input  logic [DATA_W-1:0] wb_clz_out,
  input  logic [DATA_W-1:0] wb_alu_out,
  input  logic [DATA_W-1:0] wb_dmem_out,
  input  logic [DATA_W-1:0] wb_pc4,
  input  logic [DATA_W-1:0] wb_rs_data_out,
  input  logic [DATA_W-1:0] wb_cp0_out,
  input  logic [REG_AW-1:0] wb_rf_waddr,
  input  logic              wb_rf_wena,
  input  logic              wb_hi_wena,
  input  logic              wb_lo_wena,
  input  logic [1:0]        wb_hi_mux_sel,
  input  logic [1:0]        wb_lo_mux_sel,
  input  logic [2:0]        wb_rf_mux_sel,
  output logic              rf_wena,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]       retire_cnt,
`endif
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_waddr
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] rf_mux;

  pipe_hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (wb_valid & wb_hi_wena),
    .lo_we    (wb_valid & wb_lo_wena),
    .hi_sel   (wb_hi_mux_sel),
    .lo_sel   (wb_lo_mux_sel),
    .mul_hi   (wb_mul_hi),
    .mul_lo   (wb_mul_lo),
    .div_r    (wb_div_r),
    .div_q    (wb_div_q),
    .rs_data  (wb_rs_data_out),
    .hi_q     (hi_q),
    .lo_q     (lo_q),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

  // mfhi/mflo take the committed registers, not the write-through view.
  always_comb begin
    rf_mux = '0;
    unique case (wb_rf_mux_sel)
      RF_SEL_ALU:  rf_mux = wb_alu_out;
      RF_SEL_DMEM: rf_mux = wb_dmem_out;
      RF_SEL_PC4:  rf_mux = wb_pc4;
      RF_SEL_CLZ:  rf_mux = wb_clz_out;
      RF_SEL_CP0:  rf_mux = wb_cp0_out;
      RF_SEL_HI:   rf_mux = hi_q;
      RF_SEL_LO:   rf_mux = lo_q;
      RF_SEL_MUL:  rf_mux = wb_mul_lo;
      default:     rf_mux = '0;
    endcase
  end

  assign rf_wena   = wb_valid & wb_rf_wena
                   & (wb_rf_waddr != '0) & ~rst;
  assign rf_waddr  = wb_rf_waddr;
  assign rf_wdata  = rf_wena ? rf_mux : '0;
  assign fwd_valid = rf_wena;
  assign fwd_waddr = rf_waddr;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLED) retire_cnt <= '0;
    else if (wb_valid)      retire_cnt <= retire_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Directed scoreboard bench for pipe_wb_stage.
module tb_pipe_wb_stage;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_mul_hi, wb_mul_lo, wb_div_r, wb_div_q;
  logic [31:0] wb_clz_out, wb_alu_out, wb_dmem_out;
  logic [31:0] wb_pc4, wb_rs_data_out, wb_cp0_out;
  logic [4:0]  wb_rf_waddr;
  logic        wb_rf_wena, wb_hi_wena, wb_lo_wena;
  logic [1:0]  wb_hi_mux_sel, wb_lo_mux_sel;
  logic [2:0]  wb_rf_mux_sel;
  logic        rf_wena;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_rdata, lo_rdata;
  logic        fwd_valid;
  logic [4:0]  fwd_waddr;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
  logic [63:0] exp_cnt;
`endif

  typedef struct {
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipe_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_mul_hi      (wb_mul_hi),
    .wb_mul_lo      (wb_mul_lo),
    .wb_div_r       (wb_div_r),
    .wb_div_q       (wb_div_q),
    .wb_clz_out     (wb_clz_out),
    .wb_alu_out     (wb_alu_out),
    .wb_dmem_out    (wb_dmem_out),
    .wb_pc4         (wb_pc4),
    .wb_rs_data_out (wb_rs_data_out),
    .wb_cp0_out     (wb_cp0_out),
    .wb_rf_waddr    (wb_rf_waddr),
    .wb_rf_wena     (wb_rf_wena),
    .wb_hi_wena     (wb_hi_wena),
    .wb_lo_wena     (wb_lo_wena),
    .wb_hi_mux_sel  (wb_hi_mux_sel),
    .wb_lo_mux_sel  (wb_lo_mux_sel),
    .wb_rf_mux_sel  (wb_rf_mux_sel),
    .rf_wena        (rf_wena),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .hi_rdata       (hi_rdata),
    .lo_rdata       (lo_rdata),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt     (retire_cnt),
`endif
    .fwd_valid      (fwd_valid),
    .fwd_waddr      (fwd_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WB_RETIRE_CNT_EN
  always @(posedge clk) begin
    if (rst) exp_cnt <= 64'd0;
    else if (wb_valid) exp_cnt <= exp_cnt + 64'd1;
  end
`endif

  task automatic idle();
    wb_valid = 0;
    wb_mul_hi = 0; wb_mul_lo = 0;
    wb_div_r = 0; wb_div_q = 0;
    wb_clz_out = 32'hC1C1; wb_alu_out = 32'hA1A1;
    wb_dmem_out = 32'hD1D1; wb_pc4 = 32'h0404;
    wb_rs_data_out = 0; wb_cp0_out = 32'hC0C0;
    wb_rf_waddr = 0; wb_rf_wena = 0;
    wb_hi_wena = 0; wb_lo_wena = 0;
    wb_hi_mux_sel = 2'd3; wb_lo_mux_sel = 2'd3;
    wb_rf_mux_sel = 3'd0;
  endtask

  task automatic push(input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] h,
                      input logic [31:0] l);
    exp_t e;
    e.wena = we; e.waddr = wa; e.wdata = wd; e.hi = h; e.lo = l;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".rf_wena"},   32'(rf_wena),   32'(e.wena));
      chk({tag, ".rf_waddr"},  32'(rf_waddr),  32'(e.waddr));
      chk({tag, ".rf_wdata"},  rf_wdata,       e.wdata);
      chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(e.wena));
      chk({tag, ".fwd_waddr"}, 32'(fwd_waddr), 32'(e.waddr));
      chk({tag, ".hi_rdata"},  hi_rdata,       e.hi);
      chk({tag, ".lo_rdata"},  lo_rdata,       e.lo);
    end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    assert (retire_cnt === exp_cnt) else begin
      errors++;
      $error("FAIL %s.retire_cnt: observed %0d expected %0d",
             tag, retire_cnt, exp_cnt);
    end
`endif
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    @(negedge clk);
    push(0, 0, 0, 0, 0); #1 check_out("reset");

    // RF write of alu_out
    @(negedge clk); rst = 0; idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 8;
    wb_rf_mux_sel = 3'd0; wb_alu_out = 32'h1234;
    push(1, 8, 32'h1234, 0, 0); #1 check_out("alu_wr");

    // write to $0 suppressed
    @(negedge clk); idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 0;
    wb_rf_mux_sel = 3'd1; wb_dmem_out = 32'hDEAD;
    push(0, 0, 0, 0, 0); #1 check_out("zero_reg");

    // MULT with write-through
    @(negedge clk); idle();
    wb_valid = 1; wb_hi_wena = 1; wb_lo_wena = 1;
    wb_hi_mux_sel = 2'd1; wb_lo_mux_sel = 2'd1;
    wb_mul_hi = 32'hA; wb_mul_lo = 32'hB;
    push(0, 0, 0, 32'hA, 32'hB); #1 check_out("mult");

    @(negedge clk); idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 3;
    wb_rf_mux_sel = 3'd5;
    push(1, 3, 32'hA, 32'hA, 32'hB); #1 check_out("mfhi");

    @(negedge clk); idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 3;
    wb_rf_mux_sel = 3'd6;
    push(1, 3, 32'hB, 32'hA, 32'hB); #1 check_out("mflo");

    // MUL, pc4, cp0, clz selects
    @(negedge clk); idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 31;
    wb_rf_mux_sel = 3'd7; wb_mul_lo = 32'h5A5A;
    push(1, 31, 32'h5A5A, 32'hA, 32'hB); #1 check_out("mul");

    @(negedge clk); idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 2;
    wb_rf_mux_sel = 3'd2;
    push(1, 2, 32'h0404, 32'hA, 32'hB); #1 check_out("pc4");

    @(negedge clk); idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 5;
    wb_rf_mux_sel = 3'd4;
    push(1, 5, 32'hC0C0, 32'hA, 32'hB); #1 check_out("cp0");

    @(negedge clk); idle();
    wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 6;
    wb_rf_mux_sel = 3'd3;
    push(1, 6, 32'hC1C1, 32'hA, 32'hB); #1 check_out("clz");

    // DIV then MTHI then hold
    @(negedge clk); idle();
    wb_valid = 1; wb_hi_wena = 1; wb_lo_wena = 1;
    wb_hi_mux_sel = 2'd2; wb_lo_mux_sel = 2'd2;
    wb_div_r = 7; wb_div_q = 3;
    push(0, 0, 0, 7, 3); #1 check_out("div");

    @(negedge clk); idle();
    wb_valid = 1; wb_hi_wena = 1; wb_hi_mux_sel = 2'd0;
    wb_rs_data_out = 32'h55;
    push(0, 0, 0, 32'h55, 3); #1 check_out("mthi");

    @(negedge clk); idle();
    wb_valid = 1; wb_hi_wena = 1; wb_hi_mux_sel = 2'd3;
    wb_rs_data_out = 32'h66;
    push(0, 0, 0, 32'h55, 3); #1 check_out("hi_hold");

    // MTLO, then mfhi sees committed HI while HI write pends
    @(negedge clk); idle();
    wb_valid = 1; wb_lo_wena = 1; wb_lo_mux_sel = 2'd0;
    wb_rs_data_out = 32'h44;
    push(0, 0, 0, 32'h55, 32'h44); #1 check_out("mtlo");

    @(negedge clk); idle();
    wb_valid = 1; wb_hi_wena = 1; wb_hi_mux_sel = 2'd0;
    wb_rs_data_out = 32'h77; wb_rf_wena = 1; wb_rf_waddr = 4;
    wb_rf_mux_sel = 3'd5;
    push(1, 4, 32'h55, 32'h77, 32'h44); #1 check_out("mfhi_old");

    // bubble: nothing written
    @(negedge clk); idle();
    wb_valid = 0; wb_rf_wena = 1; wb_hi_wena = 1; wb_lo_wena = 1;
    wb_hi_mux_sel = 2'd1; wb_lo_mux_sel = 2'd1;
    wb_mul_hi = 32'hFF; wb_mul_lo = 32'hEE; wb_rf_waddr = 9;
    push(0, 9, 0, 32'h77, 32'h44); #1 check_out("bubble");

    @(negedge clk); idle();
    push(0, 0, 0, 32'h77, 32'h44); #1 check_out("post_bubble");

    // rst without an edge: outputs zero, state kept
    @(negedge clk); idle();
    rst = 1;
    push(0, 0, 0, 0, 0); #1 check_out("rst_level");
    rst = 0;
    #1 push(0, 0, 0, 32'h77, 32'h44); #1 check_out("rst_no_edge");

    // sync reset drops pending HI write
    @(negedge clk); idle();
    rst = 1; wb_valid = 1; wb_hi_wena = 1;
    wb_hi_mux_sel = 2'd1; wb_mul_hi = 32'h99;
    wb_rf_wena = 1; wb_rf_waddr = 7;
    push(0, 7, 0, 0, 0); #1 check_out("rst_pending");

    @(negedge clk); rst = 0; idle();
    push(0, 0, 0, 0, 0); #1 check_out("after_rst");

    // three valid cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle();
      wb_valid = 1; wb_rf_wena = 1; wb_rf_waddr = 5'(10 + i);
      wb_alu_out = 32'(i * 16 + 1);
      push(1, 5'(10 + i), 32'(i * 16 + 1), 0, 0);
      #1 check_out("valid_run");
    end
    @(negedge clk); idle();
    push(0, 0, 0, 0, 0); #1 check_out("count3");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
